can_acceptance_filter: RTL
==========================

# can_acceptance_filter

Serial acceptance filter for the CAN receive path. It is the consumer of the CPU-written acceptance mask and acceptance code registers. It watches the destuffed receive bit stream, gathers the arbitration field (identifier, SRR/RTR, IDE) and compares it bit by bit against the code under the mask. When the receiver reports a completed frame, it issues one accept or reject pulse, so the message buffer stores only matching frames.

## Interface
Parameters: none (widths fixed by CAN 2.0B).
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- accmask  in  32  acceptance mask, {mask register 10001, mask register 10000}; bit = 1 means the bit is compared
- acccode  in  32  acceptance code, same layout
- sof  in  1  one-cycle strobe, start-of-frame bit detected
- bit_valid  in  1  one-cycle strobe, rxbit holds the next destuffed bit after SOF
- rxbit  in  1  destuffed receive bit, MSB first
- rx_done  in  1  one-cycle strobe, frame received error-free (EOF reached)
- rx_abort  in  1  one-cycle strobe, error frame, arbitration loss or bus-off
- accept  out  1  one-cycle pulse, frame matched
- reject  out  1  one-cycle pulse, frame did not match
- busy  out  1  high from the cycle after sof until decision or abort
- id_out  out  29  captured identifier; standard frame uses [28:18], with [17:0] = 0
- ide_out  out  1  captured IDE
- rtr_out  out  1  captured RTR

## Operation
- Bit mapping:
  - Base ID bit n (n = 0..10, first received first) goes to id_out[28-n] and is compared with code/mask bit 31-n.
  - Extended bit m (m = 0..17) goes to id_out[17-m] and is compared with code/mask bit 20-m.
  - RTR is compared with bit 2. IDE is compared with bit 0. Bit 1 is unused.
  - Standard frames ignore mask[20:3].
- Snapshot: accmask and acccode are latched on sof. CPU writes during a frame have no effect until the next sof.
- Mismatch flag: cleared on sof. On each compared bit, `mism <= mism | (mask_s[k] & (rxbit ^ code_s[k]))`.
- State machine, 5-bit bit counter:
  - IDLE: on sof take the snapshot, clear id_out/ide_out/rtr_out/mism and the counter, then go to BASE.
  - BASE: 11 bit_valid strobes, then go to SRRRTR.
  - SRRRTR: one bit, held in tmp, then go to IDE.
  - IDE: one bit, stored in ide_out and compared.
    - IDE = 0: rtr_out <= tmp, compare tmp against bit 2, go to WAIT.
    - IDE = 1: go to EXT (tmp was SRR and is not compared).
  - EXT: 18 bits, then go to RTRX.
  - RTRX: one bit, stored in rtr_out and compared, then go to WAIT.
  - WAIT: ignore bit_valid. On rx_done drive accept = ~mism or reject = mism and go to IDLE.
- Boundary and priority rules:
  - rx_abort in any state: go to IDLE with no pulse. id_out, ide_out and rtr_out keep their partial values.
  - rx_done before WAIT (truncated frame): treated as abort, no pulse.
  - rx_done and rx_abort in the same cycle: abort wins.
  - sof while busy, including the same cycle as rx_done or rx_abort: restart with a new snapshot; no pulse for the old frame.
  - bit_valid in IDLE: ignored.
  - accmask = 0: every completed frame is accepted.
- accept and reject are never high together. Exactly one pulse per completed frame.

## Timing
- All flops are on the rising edge of clk. rst clears state to IDLE, busy/accept/reject to 0, id_out to 0, ide_out and rtr_out to 0, mism to 0, and the snapshot to 0.
- busy rises the cycle after sof and falls in the same cycle the accept/reject pulse is high. The pulse is registered: it is high the cycle after rx_done is sampled, for exactly 1 cycle.
- The captured fields are valid from the cycle after the last arbitration bit and stay stable until the next sof.
- bit_valid arrives at most once per cycle and may be back-to-back; there is no minimum spacing.

## Test plan
- Standard exact match: mask = 0xFFE0_0005, code = 0x2460_0000. Send ID 0x123, RTR = 0, IDE = 0, then rx_done. Required: one accept pulse, id_out = 0x123 << 18, ide_out = 0.
- Standard mismatch on the last ID bit: same mask, send ID 0x122. Required: a reject pulse, no accept.
- Extended don't-care: mask = 0xFFFF_FF01, code = 0x0000_0001. Send extended ID 0x1FFF_FF00, then 0x1FFF_FFFF. Required: both rejected (bits 28..8 mismatch). Then send ID 0x0000_0010. Required: accepted, id_out = 0x10, ide_out = 1.
- Abort and truncation:
  - rx_abort in the middle of EXT: no pulse, busy = 0 the next cycle.
  - rx_done during BASE: no pulse.
  - rx_done and rx_abort in the same cycle in WAIT: no pulse.
- Snapshot plus restart: change accmask during BASE; the result must follow the old mask. Assert sof during WAIT; no pulse for the first frame, and the second frame is decided normally.
- Async reset: assert rst during EXT (not clock-aligned). All outputs are 0 immediately; the first frame after deassertion is decided correctly.

Source files
------------

// File: rtl/can_acceptance_filter.sv
// can_acceptance_filter
// Serial CAN acceptance filter. Captures the arbitration field (ID, SRR/RTR,
// IDE) from the destuffed receive stream. Each captured bit is compared with
// the acceptance code under the acceptance mask. At the end of a completed
// frame the block issues exactly one accept or reject pulse.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   accmask, acccode    acceptance mask / code (mask bit = 1 means compared)
//   sof                 start-of-frame strobe; latches mask/code, restarts
//   bit_valid, rxbit    destuffed bit strobe and value, MSB first
//   rx_done, rx_abort   frame-complete / frame-abort strobes
//   accept, reject      one-cycle decision pulses
//   busy                frame in progress (cycle after sof until decision)
//   id_out, ide_out, rtr_out  captured arbitration fields
module can_acceptance_filter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] accmask,
    input  logic [31:0] acccode,
    input  logic        sof,
    input  logic        bit_valid,
    input  logic        rxbit,
    input  logic        rx_done,
    input  logic        rx_abort,
    output logic        accept,
    output logic        reject,
    output logic        busy,
    output logic [28:0] id_out,
    output logic        ide_out,
    output logic        rtr_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BASE,
        S_SRRRTR,
        S_IDE,
        S_EXT,
        S_RTRX,
        S_WAIT
    } state_t;

    localparam int unsigned CNT_W = 5;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      mask_s;
    logic [31:0]      code_s;
    logic             mism;
    logic             tmp;

    // Bit positions for the current counter value in the base and extended fields
    logic [4:0] base_k;
    logic [4:0] ext_k;
    logic [4:0] base_pos;
    logic [4:0] ext_pos;

    assign base_k   = 5'd31 - cnt;
    assign ext_k    = 5'd20 - cnt;
    assign base_pos = 5'd28 - cnt;
    assign ext_pos  = 5'd17 - cnt;

    // Code/mask bit 1 has no arbitration bit behind it
    logic unused_bit1;
    assign unused_bit1 = ^{mask_s[1], code_s[1]};

    // Frame capture, compare and decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mask_s  <= '0;
            code_s  <= '0;
            mism    <= 1'b0;
            tmp     <= 1'b0;
            accept  <= 1'b0;
            reject  <= 1'b0;
            busy    <= 1'b0;
            id_out  <= '0;
            ide_out <= 1'b0;
            rtr_out <= 1'b0;
        end else begin
            accept <= 1'b0;
            reject <= 1'b0;
            if (sof) begin
                // sof always restarts, even mid-frame; the old frame gets no pulse
                mask_s  <= accmask;
                code_s  <= acccode;
                id_out  <= '0;
                ide_out <= 1'b0;
                rtr_out <= 1'b0;
                mism    <= 1'b0;
                cnt     <= '0;
                tmp     <= 1'b0;
                busy    <= 1'b1;
                state   <= S_BASE;
            end else if (state != S_IDLE) begin
                if (rx_abort || (rx_done && state != S_WAIT)) begin
                    // Abort or truncated frame: drop silently, keep partial fields
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end else if (rx_done) begin
                    accept <= ~mism;
                    reject <= mism;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end else if (bit_valid) begin
                    case (state)
                        S_BASE: begin
                            id_out[base_pos] <= rxbit;
                            mism <= mism | (mask_s[base_k] & (rxbit ^ code_s[base_k]));
                            if (cnt == 5'd10) begin
                                cnt   <= '0;
                                state <= S_SRRRTR;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                        S_SRRRTR: begin
                            tmp   <= rxbit;
                            state <= S_IDE;
                        end
                        S_IDE: begin
                            ide_out <= rxbit;
                            if (rxbit) begin
                                // tmp was SRR: not compared
                                mism  <= mism | (mask_s[0] & ~code_s[0]);
                                state <= S_EXT;
                            end else begin
                                rtr_out <= tmp;
                                mism    <= mism | (mask_s[0] & code_s[0])
                                                | (mask_s[2] & (tmp ^ code_s[2]));
                                state   <= S_WAIT;
                            end
                        end
                        S_EXT: begin
                            id_out[ext_pos] <= rxbit;
                            mism <= mism | (mask_s[ext_k] & (rxbit ^ code_s[ext_k]));
                            if (cnt == 5'd17) begin
                                cnt   <= '0;
                                state <= S_RTRX;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                        S_RTRX: begin
                            rtr_out <= rxbit;
                            mism    <= mism | (mask_s[2] & (rxbit ^ code_s[2]));
                            state   <= S_WAIT;
                        end
                        default: ; // S_WAIT ignores bits
                    endcase
                end
            end
        end
    end

endmodule
